data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the RAM size in 32-bit words (4 KiB).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the console FIFO depth; it SHALL be a power of 2, minimum 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1: system clock; all state updates on posedge.
- reset, in, 1: synchronous, active-high reset.
- mem_write, in, 1: store request this cycle.
- byte_enable, in, 4: lane enables; bit n selects write_data[8n+7:8n].
- address, in, 32: byte address (core ALU result).
- write_data, in, 32: lane-aligned store data.
- read_data, out, 32: combinational read of the addressed word.
- tx_valid, out, 1: console FIFO head valid.
- tx_data, out, 8: console FIFO head byte.
- tx_ready, in, 1: consumer accepts head this cycle.

Function
REQ-005 Address map, decoded on address[31:2]; address[1:0] is ignored:
- RAM: 0x0000_0000 up to 4*MEM_WORDS-1.
- CONSOLE_DATA: 0x8000_0000.
- CONSOLE_STATUS: 0x8000_0004.
- CYCLE_LO: 0x8000_0008.
- CYCLE_HI: 0x8000_000C.
REQ-006 read_data SHALL be combinational from address, with zero-cycle latency, because the single-cycle core consumes it in the same cycle.
REQ-007 RAM write SHALL occur at posedge when mem_write=1, updating only the lanes enabled in byte_enable; other lanes keep their value.
REQ-008 Reading a RAM word written in the previous cycle SHALL return the new value; a same-cycle read returns the old value.
REQ-009 Reads of unmapped addresses SHALL return 0; writes to unmapped addresses SHALL be ignored.
REQ-010 A write to CONSOLE_DATA with byte_enable[0]=1 SHALL push write_data[7:0] into the FIFO; with byte_enable[0]=0 it SHALL be ignored.
REQ-011 Reading CONSOLE_DATA SHALL return 0.
REQ-012 FIFO pop SHALL occur at posedge when tx_valid and tx_ready are both 1.
REQ-013 tx_valid SHALL be 1 exactly when the FIFO is non-empty; tx_data SHALL equal the head byte, and SHALL be 0 when empty.
REQ-014 A push while full with no pop in the same cycle SHALL be dropped and SHALL set the sticky overflow bit.
REQ-015 A push while full with a pop in the same cycle SHALL be accepted; occupancy stays full and overflow is not set.
REQ-016 A push while empty SHALL be accepted; tx_valid rises the next cycle.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with a count of width log2(FIFO_DEPTH)+1.
REQ-018 CONSOLE_STATUS read format:
- bit0: full.
- bit1: empty.
- bit2: overflow.
- bits[15:8]: occupancy count.
- all other bits: 0.
REQ-019 Any write to CONSOLE_STATUS SHALL clear overflow; if an overflow event occurs in the same cycle, the set wins.
REQ-020 The 64-bit cycle counter SHALL increment every cycle and wrap to 0 after 2^64-1.
REQ-021 CYCLE_LO and CYCLE_HI reads SHALL return bits [31:0] and [63:32] of the counter; no atomic snapshot is provided.
REQ-022 Any write to CYCLE_LO SHALL load the counter with 0 at that posedge; it then increments from 0 on the following cycles.
REQ-023 Writes to CYCLE_HI SHALL be ignored.

Reset
REQ-024 On posedge with reset=1, the following SHALL occur:
- FIFO emptied; tx_valid=0, tx_data=0.
- overflow=0.
- cycle counter=0.
- pending push, pop and store ignored.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 read_data SHALL remain combinational during reset.
REQ-027 Reset asserted mid-stream SHALL discard all queued bytes; the first push after reset deassertion SHALL become the head.

Structure
REQ-028 A shared package SHALL hold the map base addresses, the status bit positions and the MEM_WORDS default.
REQ-029 The console queue SHALL be one sub-module, byte_fifo, parameterised by depth, exposing push, pop, full, empty, count and overflow.
REQ-030 RAM SHALL be an inferred array inside data_bus_responder.

Verification
REQ-031 SHALL cover:
- Byte-lane store: write 0x11223344 to 0x10 with be=1111, then 0xAA with be=0100, read 0x10 -> 0x11AA3344.
- Unmapped access: write 0xDEAD to 0x4000_0000 with be=1111, read -> 0; all RAM unchanged.
- Console burst: tx_ready=0, push 0x41..0x48 (8 bytes) -> status=0x0000_0801; 9th push -> bit2 set and count stays 8.
- Full drain and overflow clear: raise tx_ready -> bytes 0x41..0x48 appear in order, one per cycle; then write status -> overflow=0, empty=1.
- Simultaneous push/pop: with FIFO full and tx_ready=1, push 0x5A -> count stays 8, no overflow, 0x5A exits last.
- Counter and reset: after 5 cycles post-reset, CYCLE_LO reads 5; write CYCLE_LO -> next-cycle read 1; assert reset with 3 queued bytes -> tx_valid=0 next cycle.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared address map, console status layout and region decode for the data bus responder.
package data_bus_responder_pkg;

  // Default RAM size in 32-bit words (4 KiB).
  localparam int unsigned MemWordsDefault = 1024;

  // Memory-mapped register byte addresses.
  localparam logic [31:0] ConsoleDataAddr   = 32'h8000_0000;
  localparam logic [31:0] ConsoleStatusAddr = 32'h8000_0004;
  localparam logic [31:0] CycleLoAddr       = 32'h8000_0008;
  localparam logic [31:0] CycleHiAddr       = 32'h8000_000C;

  // Console status word layout.
  localparam int unsigned StatusFullBit    = 0;
  localparam int unsigned StatusEmptyBit   = 1;
  localparam int unsigned StatusOvfBit     = 2;
  localparam int unsigned StatusCountLsb   = 8;
  localparam int unsigned StatusCountWidth = 8;

  typedef enum logic [2:0] {
    RegRam,
    RegConData,
    RegConStatus,
    RegCycLo,
    RegCycHi,
    RegNone
  } region_e;

  // Decode a word address (byte address bits [31:2]) into a target region.
  function automatic region_e decode_region(input logic [29:0] word,
                                            input int unsigned mem_words);
    if ({2'b00, word} < mem_words) return RegRam;
    if (word == ConsoleDataAddr[31:2]) return RegConData;
    if (word == ConsoleStatusAddr[31:2]) return RegConStatus;
    if (word == CycleLoAddr[31:2]) return RegCycLo;
    if (word == CycleHiAddr[31:2]) return RegCycHi;
    return RegNone;
  endfunction

endpackage

// File: rtl/data_bus_responder_byte_fifo.sv
// Console byte queue: power-of-two depth ring buffer with sticky overflow flag.
module byte_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  input  logic                     clr_ovf_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o,
  output logic [7:0]               head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pop_ok, push_ok, ovf_evt;

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign head_o     = empty_o ? 8'h00 : mem_q[rd_q];

  // A pop frees a slot in the same cycle, so a push while full is accepted alongside it.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign ovf_evt = push_i & full_o & ~pop_ok;

  // Next occupancy and overflow; an overflow event beats a clear in the same cycle.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Pointer, count and flag state; pointers wrap naturally at Depth.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Byte storage is not reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-side bus target for a single-cycle core: RAM, console TX queue and a cycle counter.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = MemWordsDefault,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  region_e         region;
  logic [IdxW-1:0] ram_idx;
  logic [31:0]     ram_q [MEM_WORDS];
  logic            ram_we, con_push, status_wr, cyc_lo_wr, fifo_pop;
  logic            fifo_full, fifo_empty, fifo_ovf;
  logic [CntW-1:0] fifo_count;
  logic [63:0]     cycle_q, cycle_d;
  logic [31:0]     status_word;
  logic            unused_addr_lsb;

  // Byte offset within a word never affects decode.
  assign unused_addr_lsb = ^address[1:0];

  assign region  = decode_region(address[31:2], MEM_WORDS);
  assign ram_idx = address[IdxW+1:2];

  assign ram_we    = mem_write & (region == RegRam);
  assign con_push  = mem_write & (region == RegConData) & byte_enable[0];
  assign status_wr = mem_write & (region == RegConStatus);
  assign cyc_lo_wr = mem_write & (region == RegCycLo);
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;

  byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_byte_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (con_push),
    .data_i     (write_data[7:0]),
    .pop_i      (fifo_pop),
    .clr_ovf_i  (status_wr),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_ovf),
    .head_o     (tx_data)
  );

  // Lane-masked RAM store; contents survive reset but a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) begin
          ram_q[ram_idx][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  // Free-running counter; a CYCLE_LO write restarts it from zero.
  always_comb begin
    cycle_d = cyc_lo_wr ? 64'd0 : cycle_q + 64'd1;
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  // Console status word assembly.
  always_comb begin
    status_word = '0;
    status_word[StatusFullBit]  = fifo_full;
    status_word[StatusEmptyBit] = fifo_empty;
    status_word[StatusOvfBit]   = fifo_ovf;
    status_word[StatusCountLsb +: StatusCountWidth] = StatusCountWidth'(fifo_count);
  end

  // Zero-latency read mux; the core consumes the result in the same cycle.
  always_comb begin
    read_data = '0;
    case (region)
      RegRam:       read_data = ram_q[ram_idx];
      RegConStatus: read_data = status_word;
      RegCycLo:     read_data = cycle_q[31:0];
      RegCycHi:     read_data = cycle_q[63:32];
      default:      read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed table, corner sequences, random vs model.
module tb_data_bus_responder;

  localparam int unsigned MEM   = 1024;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] ACData = 32'h8000_0000;
  localparam logic [31:0] AStat  = 32'h8000_0004;
  localparam logic [31:0] ACLo   = 32'h8000_0008;
  localparam logic [31:0] ACHi   = 32'h8000_000C;

  logic        clk, reset, mem_write, tx_valid, tx_ready;
  logic [3:0]  byte_enable;
  logic [31:0] address, write_data, read_data;
  logic [7:0]  tx_data;

  data_bus_responder #(
    .MEM_WORDS  (MEM),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_write   (mem_write),
    .byte_enable (byte_enable),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [31:0] m_ram [MEM];
  bit          m_init [MEM];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [63:0] m_cyc;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (w < MEM) return m_ram[w];
    if (w == (AStat >> 2))
      return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH};
    if (w == (ACLo >> 2)) return m_cyc[31:0];
    if (w == (ACHi >> 2)) return m_cyc[63:32];
    return 32'h0;
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (w < MEM) return m_init[w];
    return 1'b1;
  endfunction

  // Apply the rules of one clock edge to the model using the currently driven inputs.
  task automatic m_clock();
    int unsigned w;
    bit pop, push, ovf_evt;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 64'd0;
      return;
    end
    w = address >> 2;
    pop = (m_q.size() != 0) && tx_ready;
    push = mem_write && (w == (ACData >> 2)) && byte_enable[0];
    ovf_evt = push && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !ovf_evt) m_q.push_back(write_data[7:0]);
    if (ovf_evt) m_ovf = 1'b1;
    else if (mem_write && w == (AStat >> 2)) m_ovf = 1'b0;
    if (mem_write && w == (ACLo >> 2)) m_cyc = 64'd0;
    else m_cyc = m_cyc + 64'd1;
    if (mem_write && w < MEM) begin
      for (int i = 0; i < 4; i++)
        if (byte_enable[i]) m_ram[w][8*i +: 8] = write_data[8*i +: 8];
      if (byte_enable == 4'hF) m_init[w] = 1'b1;
    end
  endtask

  // Drive inputs, let them settle, compare combinational outputs with the model.
  task automatic drive(input logic rst, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    reset = rst; mem_write = we; byte_enable = be; address = a; write_data = wd;
    tx_ready = rdy;
    #2;
    if (chk_en) begin
      check("model_tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      check("model_tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
      if (m_known(a)) check("model_read_data", read_data, m_read(a));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic step(input logic rst, input logic we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    drive(rst, we, be, a, wd, rdy);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;

    vecs[0]  = '{1'b1, 4'hF, 32'h10,        32'h1122_3344, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h4, 32'h10,        32'h00AA_0000, 1'b1, 32'h1122_3344};
    vecs[2]  = '{1'b0, 4'h0, 32'h10,        32'h0,         1'b1, 32'h11AA_3344};
    vecs[3]  = '{1'b0, 4'h0, 32'h13,        32'h0,         1'b1, 32'h11AA_3344};
    vecs[4]  = '{1'b1, 4'hF, 32'h4000_0000, 32'h0000_DEAD, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 4'h0, 32'h4000_0000, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, ACData,        32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, AStat,         32'h0,         1'b1, 32'h0000_0002};
    vecs[8]  = '{1'b1, 4'hF, ACHi,          32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, ACHi,          32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 4'hF, 32'h1000,      32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 4'h0, 32'h1000,      32'h0,         1'b1, 32'h0};

    step(1, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 0, 4'h0, 32'h0, 32'h0, 0);
    chk_en = 1'b1;

    // Give every RAM word a known value.
    for (int i = 0; i < int'(MEM); i++)
      step(0, 1, 4'hF, 32'(i) << 2, (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000, 0);

    // Counter from reset, then restart via CYCLE_LO.
    step(1, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0, ACLo, 32'h0, 0);
    drive(0, 0, 4'h0, ACLo, 32'h0, 0);
    check("cycle_lo_after_5", read_data, 32'd5);
    tick();
    step(0, 1, 4'hF, ACLo, 32'h1234_5678, 0);
    drive(0, 0, 4'h0, ACLo, 32'h0, 0);
    check("cycle_lo_reload", read_data, 32'd0);
    tick();
    drive(0, 0, 4'h0, ACLo, 32'h0, 0);
    check("cycle_lo_next", read_data, 32'd1);
    tick();

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      drive(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, 0);
      if (vecs[i].chk) check($sformatf("vec%0d_read", i), read_data, vecs[i].exp);
      tick();
    end

    // RAM must be untouched by the unmapped stores.
    for (int i = 0; i < int'(MEM); i++) step(0, 0, 4'h0, 32'(i) << 2, 32'h0, 0);

    // Console burst into a stalled consumer.
    for (int i = 0; i < 8; i++) step(0, 1, 4'h1, ACData, 32'h41 + 32'(i), 0);
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("status_full", read_data, 32'h0000_0801);
    tick();
    step(0, 1, 4'h1, ACData, 32'h49, 0);
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("status_overflow", read_data, 32'h0000_0805);
    tick();
    step(0, 1, 4'hE, ACData, 32'h4A, 0);
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("status_be0_ignored", read_data, 32'h0000_0805);
    tick();

    // Drain in order, then clear overflow.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 4'h0, 32'h0, 32'h0, 1);
      check("drain_valid", 32'(tx_valid), 32'd1);
      check("drain_byte", 32'(tx_data), 32'h41 + 32'(i));
      tick();
    end
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("status_drained", read_data, 32'h0000_0006);
    tick();
    step(0, 1, 4'h0, AStat, 32'h0, 0);
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("status_cleared", read_data, 32'h0000_0002);
    tick();

    // Push while full with a simultaneous pop.
    for (int i = 0; i < 8; i++) step(0, 1, 4'h1, ACData, 32'h61 + 32'(i), 0);
    drive(0, 1, 4'h1, ACData, 32'h5A, 1);
    check("swap_head", 32'(tx_data), 32'h61);
    tick();
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("status_swap", read_data, 32'h0000_0801);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 4'h0, 32'h0, 32'h0, 1);
      check("swap_drain", 32'(tx_data), (i == 7) ? 32'h5A : 32'h62 + 32'(i));
      tick();
    end

    // Reset with bytes queued and a store pending.
    for (int i = 0; i < 3; i++) step(0, 1, 4'h1, ACData, 32'h31 + 32'(i), 0);
    drive(1, 1, 4'hF, 32'h20, 32'hFFFF_FFFF, 1);
    check("pre_reset_valid", 32'(tx_valid), 32'd1);
    tick();
    drive(0, 0, 4'h0, 32'h20, 32'h0, 0);
    check("post_reset_valid", 32'(tx_valid), 32'd0);
    check("post_reset_data", 32'(tx_data), 32'd0);
    tick();
    step(0, 1, 4'h1, ACData, 32'h77, 0);
    drive(0, 0, 4'h0, AStat, 32'h0, 0);
    check("first_after_reset", 32'(tx_data), 32'h77);
    tick();
    step(0, 0, 4'h0, 32'h0, 32'h0, 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2: a = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
        3:       a = ACData;
        4:       a = AStat;
        5:       a = ACLo;
        6:       a = ACHi;
        default: a = ($urandom_range(0, 1) == 0) ? 32'h1000 + (32'($urandom_range(0, 255)) << 2)
                                                 : 32'hC000_0010;
      endcase
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 4'($urandom),
           a, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
